// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes shared with the ALU, sequencer state encoding and instruction field positions
package cpu_pkg;
  localparam logic [3:0] OP_NOP = 4'h0, OP_WRITE = 4'h1, OP_READ = 4'h2, OP_COPY = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4, OP_AND = 4'h5, OP_OR = 4'h6, OP_XOR = 4'h7;
  localparam logic [3:0] OP_NAND = 4'h8, OP_NOR = 4'h9, OP_ADD = 4'hA, OP_SUB = 4'hB;
  localparam logic [3:0] OP_ADDI = 4'hC, OP_SUBI = 4'hD, OP_LSHIFT = 4'hE, OP_RSHIFT = 4'hF;
  localparam int OPC_LSB = 8;
  localparam int RD_LSB = 6;
  localparam int RS_LSB = 4;
  localparam int IMM_LSB = 0;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_DONE, S_ERROR
  } state_t;
endpackage

// File: rtl/instr_decode.sv
// instr_decode: opcode to operand-select and writeback class flags
module instr_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       op2_sel,
  output logic       writes_reg,
  output logic       is_read,
  output logic       is_arith
);
  assign op2_sel = opcode inside {OP_WRITE, OP_ADDI, OP_SUBI, OP_LSHIFT, OP_RSHIFT};
  assign is_read = opcode == OP_READ;
  assign writes_reg = !(opcode inside {OP_NOP, OP_READ});
  assign is_arith = opcode inside {OP_ADD, OP_SUB, OP_ADDI, OP_SUBI};
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/execute/writeback sequencer driving an external ALU and register file
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W = 4,
  parameter bit HALT_ON_OVF = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [PC_W-1:0] prog_len,
  output logic [PC_W-1:0] instr_addr,
  input  logic [11:0]     instr_data,
  output logic [3:0]      alu_op,
  output logic            execute_st,
  output logic            overflow_st,
  output logic [1:0]      rd_addr1,
  output logic [1:0]      rd_addr2,
  output logic            op2_sel,
  output logic [3:0]      imm,
  input  logic            alu_overflow,
  output logic            wr_en,
  output logic [1:0]      wr_addr,
  output logic            rd_valid,
  output logic            busy,
  output logic            done,
  output logic            error
);
  state_t state;
  logic [PC_W-1:0] pc, last;
  logic [11:0] ir;
  logic sel_imm, writes_reg, is_read, is_arith, abort, ex, wb;
  instr_decode u_dec (
    .opcode(ir[OPC_LSB+:4]),
    .op2_sel(sel_imm),
    .writes_reg(writes_reg),
    .is_read(is_read),
    .is_arith(is_arith)
  );
  assign abort = HALT_ON_OVF && alu_overflow && is_arith;
  assign ex = state == S_EXECUTE;
  assign wb = state == S_WRITEBACK;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc <= '0;
      last <= '0;
      ir <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          last <= prog_len;
          state <= S_FETCH;
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir <= instr_data;
          state <= S_EXECUTE;
        end
        S_EXECUTE: state <= S_WRITEBACK;
        // compare before increment so the last address never wraps pc
        S_WRITEBACK: if (abort) state <= S_ERROR;
          else if (pc == last) state <= S_DONE;
          else begin
            pc <= pc + 1'b1;
            state <= S_FETCH;
          end
        S_DONE: begin
          pc <= '0;
          state <= S_IDLE;
        end
        default: state <= S_ERROR;
      endcase
    end
  end
  // every output is forced low while rst is high, including the cycle it is first seen
  assign instr_addr = rst ? '0 : pc;
  assign alu_op = (!rst && (ex || wb)) ? ir[OPC_LSB+:4] : 4'h0;
  assign execute_st = !rst && ex;
  assign overflow_st = !rst && ex;
  assign rd_addr1 = rst ? 2'b0 : ir[RD_LSB+:2];
  assign rd_addr2 = rst ? 2'b0 : ir[RS_LSB+:2];
  assign wr_addr = rd_addr1;
  assign imm = rst ? 4'h0 : ir[IMM_LSB+:4];
  assign op2_sel = !rst && sel_imm;
  assign wr_en = !rst && wb && writes_reg && !abort;
  assign rd_valid = !rst && wb && is_read;
  assign busy = !rst && state != S_IDLE;
  assign done = !rst && state == S_DONE;
  assign error = !rst && state == S_ERROR;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: halting and non-halting sequencers run the same programs against a cycle-timeline model
module tb_alu_sequencer;
  logic clk = 0;
  logic rst, start;
  logic [3:0] prog_len;
  logic [11:0] mem [16];
  logic ovf_tab [16];
  logic [3:0] addr [2], op [2], imm [2];
  logic [1:0] rd1 [2], rd2 [2], wad [2];
  logic ex [2], ov [2], o2 [2], we [2], rv [2], bz [2], dn [2], er [2], ovf [2];
  logic [11:0] data [2];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_sequencer #(.PC_W(4), .HALT_ON_OVF(g == 0)) u_dut (
      .clk(clk), .rst(rst), .start(start), .prog_len(prog_len),
      .instr_addr(addr[g]), .instr_data(data[g]), .alu_op(op[g]),
      .execute_st(ex[g]), .overflow_st(ov[g]), .rd_addr1(rd1[g]), .rd_addr2(rd2[g]),
      .op2_sel(o2[g]), .imm(imm[g]), .alu_overflow(ovf[g]), .wr_en(we[g]),
      .wr_addr(wad[g]), .rd_valid(rv[g]), .busy(bz[g]), .done(dn[g]), .error(er[g])
    );
  end
  always @(posedge clk) for (int i = 0; i < 2; i++) data[i] <= mem[addr[i]];
  always_comb for (int i = 0; i < 2; i++) ovf[i] = ovf_tab[addr[i]];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] outs(input int g);
    return {6'b0, addr[g], op[g], ex[g], ov[g], rd1[g], rd2[g], o2[g], imm[g],
            we[g], wad[g], rv[g], bz[g], dn[g], er[g]};
  endfunction
  task automatic reset_pulse();
    rst = 1;
    start = 0;
    #1 for (int g = 0; g < 2; g++) check($sformatf("rst_held%0d", g), outs(g), 0);
    @(negedge clk);
    rst = 0;
    #1 for (int g = 0; g < 2; g++) check($sformatf("rst_idle%0d", g), outs(g), 0);
  endtask
  task automatic clear_prog();
    for (int i = 0; i < 16; i++) begin
      mem[i] = 12'h000;
      ovf_tab[i] = 0;
    end
  endtask
  task automatic run(input int len, input int spur, input int rst_at);
    int stop [2], nbz [2], ndn [2];
    bit ab [2];
    int n, idx, ph;
    logic [11:0] w;
    logic [3:0] opc, ea, eo;
    logic [6:0] ef;
    @(negedge clk);
    reset_pulse();
    for (int g = 0; g < 2; g++) begin
      stop[g] = len;
      ab[g] = 0;
      nbz[g] = 0;
      ndn[g] = 0;
    end
    for (int i = len; i >= 0; i--)
      if (ovf_tab[i] && mem[i][11:8] >= 4'hA && mem[i][11:8] <= 4'hD) begin
        stop[0] = i;
        ab[0] = 1;
      end
    prog_len = 4'(len);
    start = 1;
    for (int k = 1; k <= 4 * (len + 1) + 3; k++) begin
      @(negedge clk);
      start = (k == spur);
      if (k == rst_at) begin
        reset_pulse();
        return;
      end
      for (int g = 0; g < 2; g++) begin
        n = 4 * (stop[g] + 1);
        ef = '0;
        ea = 0;
        eo = 0;
        if (k <= n) begin
          idx = (k - 1) / 4;
          ph = (k - 1) % 4;
          w = mem[idx];
          opc = w[11:8];
          ea = 4'(idx);
          eo = (ph >= 2) ? opc : 4'h0;
          ef = {1'b1, 1'b0, 1'b0, ph == 2, ph == 2,
                ph == 3 && opc != 0 && opc != 2 && !(ab[g] && idx == stop[g]),
                ph == 3 && opc == 2};
          if (ph >= 2)
            check($sformatf("fields%0d_k%0d", g, k), {wad[g], rd1[g], rd2[g], imm[g], o2[g]},
                  {w[7:6], w[7:6], w[5:4], w[3:0], opc == 1 || opc >= 4'hC});
        end else if (ab[g]) begin
          ea = 4'(stop[g]);
          ef = 7'b1010000;
        end else if (k == n + 1) begin
          ea = 4'(len);
          ef = 7'b1100000;
        end
        check($sformatf("flags%0d_k%0d", g, k), {bz[g], dn[g], er[g], ex[g], ov[g], we[g], rv[g]}, ef);
        check($sformatf("addr%0d_k%0d", g, k), addr[g], ea);
        check($sformatf("op%0d_k%0d", g, k), op[g], eo);
        nbz[g] += int'(bz[g] && !dn[g]);
        ndn[g] += int'(dn[g]);
      end
    end
    for (int g = 0; g < 2; g++) begin
      check($sformatf("done_cnt%0d", g), ndn[g], ab[g] ? 0 : 1);
      if (!ab[g]) check($sformatf("busy_cnt%0d", g), nbz[g], 4 * (len + 1));
    end
  endtask
  initial begin
    rst = 1;
    start = 0;
    prog_len = 0;
    clear_prog();
    mem[0] = 12'h105;
    mem[1] = 12'hC03;
    run(1, 0, 0);
    clear_prog();
    mem[0] = 12'hA40;
    ovf_tab[0] = 1;
    run(1, 0, 0);
    clear_prog();
    mem[0] = 12'h280;
    run(0, 0, 0);
    clear_prog();
    mem[0] = 12'h105;
    mem[1] = 12'h1A2;
    mem[2] = 12'h2C0;
    mem[3] = 12'h7D3;
    run(3, 3, 0);
    run(3, 0, 3);
    run(3, 0, 0);
    clear_prog();
    run(15, 0, 0);
    repeat (40) begin
      int len, s, r;
      len = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) begin
        mem[i] = 12'($urandom);
        ovf_tab[i] = ($urandom_range(0, 3) == 0);
      end
      s = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4 * (len + 1) + 1) : 0;
      r = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4 * (len + 1)) : 0;
      run(len, (r != 0) ? 0 : s, r);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
